deserializer: RTL and testbench
===============================

DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the lane and word width in bits.
REQ-002 Port CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port RESET  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 Port I  input  WIDTH  SHALL carry the serial word stream.
REQ-005 Port I_VALID  input  1  SHALL qualify I.
REQ-006 Port I_SOF  input  1  SHALL mark I as lane 0 (start of frame); meaningful only with I_VALID.
REQ-007 Port I_READY  output  1  SHALL indicate the block accepts I this cycle.
REQ-008 Ports O0, O1, O2, O3  output  WIDTH each  SHALL present the reassembled frame lanes 0..3.
REQ-009 Port O_VALID  output  1  SHALL qualify O0..O3.
REQ-010 Port O_READY  input  1  SHALL indicate the consumer takes O0..O3 this cycle.
REQ-011 Port ERR  output  1  SHALL pulse high for one cycle on a framing error.
REQ-012 Port ERR_CNT  output  8  SHALL count framing errors, saturating at 255.

Function
REQ-013 An input accept SHALL occur when I_VALID && I_READY; an output transfer SHALL occur when O_VALID && O_READY.
REQ-014 The block SHALL hold a 2-bit lane counter cnt (0..3) and three shadow registers s0..s2 of WIDTH bits.
REQ-015 I_READY SHALL be combinational: low only when cnt==3 && O_VALID && !O_READY; high otherwise.
REQ-016 Accept with I_SOF=1 and cnt==0: store I in s0; cnt SHALL become 1.
REQ-017 Accept with I_SOF=1 and cnt!=0: the partial frame SHALL be discarded, ERR SHALL pulse, and I SHALL be stored in s0 with cnt=1 (resync).
REQ-018 Accept with I_SOF=0 and cnt==0: the word SHALL be dropped, ERR SHALL pulse, and cnt SHALL stay 0.
REQ-019 Accept with I_SOF=0 and cnt==1 or 2: store I in s1 or s2 respectively; cnt increments.
REQ-020 Accept with I_SOF=0 and cnt==3 (frame completion): O0..O3 SHALL load s0, s1, s2, I; O_VALID SHALL be 1 after that edge; cnt SHALL wrap to 0.
REQ-021 Accept with I_SOF=1 at cnt==3 SHALL follow REQ-017 (no completion).
REQ-022 Latency: the final lane word accepted at edge k SHALL appear on O0..O3 with O_VALID=1 immediately after edge k.
REQ-023 Output transfer without a same-cycle completion SHALL clear O_VALID; O0..O3 SHALL retain their last values.
REQ-024 Output transfer coincident with a completion SHALL keep O_VALID=1 and load the new frame (back-to-back, zero bubble).
REQ-025 While O_VALID && !O_READY, O0..O3 SHALL remain stable; lanes 0..2 of the next frame SHALL still be accepted into s0..s2.
REQ-026 Sustained throughput SHALL be one word per cycle, i.e. one frame per 4 cycles, when O_READY is held high.
REQ-027 ERR_CNT SHALL increment by 1 on every ERR pulse and hold at 255.
REQ-028 No state SHALL change on cycles without an accept or transfer, except ERR returning to 0.

Reset
REQ-029 Asserting RESET SHALL immediately force cnt=0, O_VALID=0, ERR=0, ERR_CNT=0, O0..O3=0, s0..s2=0, independent of CLK.
REQ-030 Reset mid-frame SHALL discard the partial frame; the first accept after release requires I_SOF=1.
REQ-031 I_READY SHALL be 1 while and after RESET is asserted (cnt=0, O_VALID=0).

Verification
REQ-032 Frame 0x1111(SOF),0x2222,0x3333,0x4444 on 4 consecutive cycles, O_READY=1 -> O_VALID=1 for one cycle with O0..O3=0x1111,0x2222,0x3333,0x4444.
REQ-033 Two back-to-back frames, O_READY=1 -> O_VALID high on cycles 4 and 8 only, correct lanes each frame, I_READY constant 1.
REQ-034 O_READY=0 after frame 1, frame 2 streamed -> I_READY drops at frame-2 lane 3; O0..O3 hold frame 1; raising O_READY transfers frame 1 and frame 2 appears the next cycle.
REQ-035 SOF,0xA,SOF,0xB,0xC,0xD -> one ERR pulse, ERR_CNT=1, output frame = second SOF word,0xB,0xC,0xD.
REQ-036 Non-SOF word at cnt==0 repeated 300 times -> 300 ERR pulses, ERR_CNT saturates at 255, O_VALID stays 0.
REQ-037 RESET asserted after 2 lanes, then released and a full frame sent -> only the new frame output, ERR_CNT=0.

Source files
------------

// File: rtl/deserializer.sv
// Four-lane word deserializer: collects SOF-delimited 4-word frames from a
// serial word stream and presents them as one wide registered output beat.
// Framing errors (misplaced SOF, orphan word) pulse ERR and bump a saturating counter.
module deserializer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I,
    input  logic             I_VALID,
    input  logic             I_SOF,
    output logic             I_READY,
    output logic [WIDTH-1:0] O0,
    output logic [WIDTH-1:0] O1,
    output logic [WIDTH-1:0] O2,
    output logic [WIDTH-1:0] O3,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic             ERR,
    output logic [7:0]       ERR_CNT
);

    localparam int unsigned CNT_W   = 2;
    localparam int unsigned ECNT_W  = 8;
    localparam logic [CNT_W-1:0]  LANE0 = CNT_W'(0);
    localparam logic [CNT_W-1:0]  LANE1 = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LANE2 = CNT_W'(2);
    localparam logic [CNT_W-1:0]  LANE3 = CNT_W'(3);
    localparam logic [ECNT_W-1:0] ECNT_MAX = ECNT_W'(255);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    logic accept;
    logic xfer;
    logic complete;
    logic frame_err;

    // Only the final lane can stall: it needs the output register to be free.
    assign I_READY   = !((cnt == LANE3) && O_VALID && !O_READY);
    assign accept    = I_VALID && I_READY;
    assign xfer      = O_VALID && O_READY;
    assign complete  = accept && !I_SOF && (cnt == LANE3);
    assign frame_err = accept && (I_SOF ? (cnt != LANE0) : (cnt == LANE0));

    // Lane counter and shadow capture of lanes 0..2; SOF always resyncs to lane 1.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= LANE0;
            s0  <= '0;
            s1  <= '0;
            s2  <= '0;
        end else if (accept) begin
            if (I_SOF) begin
                s0  <= I;
                cnt <= LANE1;
            end else if (cnt == LANE1) begin
                s1  <= I;
                cnt <= LANE2;
            end else if (cnt == LANE2) begin
                s2  <= I;
                cnt <= LANE3;
            end else if (cnt == LANE3) begin
                cnt <= LANE0;
            end
        end
    end

    // Output frame register, loaded with the shadows plus the last lane on completion.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            O0 <= '0;
            O1 <= '0;
            O2 <= '0;
            O3 <= '0;
        end else if (complete) begin
            O0 <= s0;
            O1 <= s1;
            O2 <= s2;
            O3 <= I;
        end
    end

    // Output valid: set by completion (wins over a same-cycle transfer), cleared by transfer.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            O_VALID <= 1'b0;
        end else if (complete) begin
            O_VALID <= 1'b1;
        end else if (xfer) begin
            O_VALID <= 1'b0;
        end
    end

    // Framing error pulse and saturating error counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ERR     <= 1'b0;
            ERR_CNT <= '0;
        end else begin
            ERR <= frame_err;
            if (frame_err && (ERR_CNT != ECNT_MAX)) begin
                ERR_CNT <= ERR_CNT + ECNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: table vectors, directed multi-cycle scenarios and
// randomized traffic checked against a queue-based frame model.
module tb_deserializer;

    localparam int unsigned W = 16;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [W-1:0] I;
    logic         I_VALID;
    logic         I_SOF;
    logic         I_READY;
    logic [W-1:0] O0, O1, O2, O3;
    logic         O_VALID;
    logic         O_READY;
    logic         ERR;
    logic [7:0]   ERR_CNT;

    deserializer #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .I(I), .I_VALID(I_VALID), .I_SOF(I_SOF),
        .I_READY(I_READY), .O0(O0), .O1(O1), .O2(O2), .O3(O3),
        .O_VALID(O_VALID), .O_READY(O_READY), .ERR(ERR), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending partial frame as a queue, output frame as an array.
    logic [W-1:0] m_part[$];
    logic [W-1:0] m_o[4];
    logic         m_ov;
    logic         m_err;
    int           m_ecnt;
    logic         rdy_seen;

    typedef struct {
        logic [W-1:0] i;
        logic         v;
        logic         sof;
        logic         ordy;
        logic         rdy;
        logic         ov;
        logic         err;
        logic [7:0]   ecnt;
        logic [W-1:0] o0, o1, o2, o3;
    } vec_t;

    vec_t vec[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_part.delete();
        for (int k = 0; k < 4; k++) m_o[k] = '0;
        m_ov   = 1'b0;
        m_err  = 1'b0;
        m_ecnt = 0;
    endtask

    function automatic logic model_ready(input logic ordy);
        return !((m_part.size() == 3) && m_ov && !ordy);
    endfunction

    task automatic model_step(input logic [W-1:0] w, input logic v, input logic sof,
                              input logic ordy);
        logic acc, xf, done;
        acc   = v && model_ready(ordy);
        xf    = m_ov && ordy;
        done  = 1'b0;
        m_err = 1'b0;
        if (acc) begin
            if (sof) begin
                if (m_part.size() != 0) m_err = 1'b1;
                m_part.delete();
                m_part.push_back(w);
            end else if (m_part.size() == 0) begin
                m_err = 1'b1;
            end else begin
                m_part.push_back(w);
                if (m_part.size() == 4) begin
                    for (int k = 0; k < 4; k++) m_o[k] = m_part[k];
                    m_part.delete();
                    done = 1'b1;
                end
            end
        end
        if (done) m_ov = 1'b1;
        else if (xf) m_ov = 1'b0;
        if (m_err && m_ecnt < 255) m_ecnt++;
    endtask

    task automatic compare_model();
        chk("o_valid", 32'(O_VALID), 32'(m_ov));
        chk("err", 32'(ERR), 32'(m_err));
        chk("err_cnt", 32'(ERR_CNT), 32'(m_ecnt));
        chk("o0", 32'(O0), 32'(m_o[0]));
        chk("o1", 32'(O1), 32'(m_o[1]));
        chk("o2", 32'(O2), 32'(m_o[2]));
        chk("o3", 32'(O3), 32'(m_o[3]));
    endtask

    // One clock: drive at negedge, check ready, step model at posedge, compare after.
    task automatic cycle(input logic [W-1:0] w, input logic v, input logic sof,
                         input logic ordy);
        I = w; I_VALID = v; I_SOF = sof; O_READY = ordy;
        #1;
        rdy_seen = I_READY;
        chk("i_ready", 32'(I_READY), 32'(model_ready(ordy)));
        @(posedge CLK);
        model_step(w, v, sof, ordy);
        #1;
        compare_model();
        @(negedge CLK);
    endtask

    // Asynchronous reset pulse applied mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        @(negedge CLK);
        I_VALID = 1'b0; I_SOF = 1'b0; O_READY = 1'b0; I = '0;
        RESET = 1'b1;
        #2;
        model_reset();
        chk("rst_o_valid", 32'(O_VALID), 32'd0);
        chk("rst_err_cnt", 32'(ERR_CNT), 32'd0);
        chk("rst_o0", 32'(O0), 32'd0);
        chk("rst_o3", 32'(O3), 32'd0);
        chk("rst_i_ready", 32'(I_READY), 32'd1);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b0; I = '0; I_VALID = 1'b0; I_SOF = 1'b0; O_READY = 1'b0;
        model_reset();

        // Table vectors: single frame, idle transfer, SOF resync, orphan word.
        vec[0]  = '{16'h1111,1,1,1, 1,0,0,8'd0, 16'h0,16'h0,16'h0,16'h0};
        vec[1]  = '{16'h2222,1,0,1, 1,0,0,8'd0, 16'h0,16'h0,16'h0,16'h0};
        vec[2]  = '{16'h3333,1,0,1, 1,0,0,8'd0, 16'h0,16'h0,16'h0,16'h0};
        vec[3]  = '{16'h4444,1,0,1, 1,1,0,8'd0, 16'h1111,16'h2222,16'h3333,16'h4444};
        vec[4]  = '{16'h0000,0,0,1, 1,0,0,8'd0, 16'h1111,16'h2222,16'h3333,16'h4444};
        vec[5]  = '{16'h00F1,1,1,1, 1,0,0,8'd0, 16'h1111,16'h2222,16'h3333,16'h4444};
        vec[6]  = '{16'h000A,1,0,1, 1,0,0,8'd0, 16'h1111,16'h2222,16'h3333,16'h4444};
        vec[7]  = '{16'h00F2,1,1,1, 1,0,1,8'd1, 16'h1111,16'h2222,16'h3333,16'h4444};
        vec[8]  = '{16'h000B,1,0,1, 1,0,0,8'd1, 16'h1111,16'h2222,16'h3333,16'h4444};
        vec[9]  = '{16'h000C,1,0,1, 1,0,0,8'd1, 16'h1111,16'h2222,16'h3333,16'h4444};
        vec[10] = '{16'h000D,1,0,1, 1,1,0,8'd1, 16'h00F2,16'h000B,16'h000C,16'h000D};
        vec[11] = '{16'h5555,1,0,1, 1,0,1,8'd2, 16'h00F2,16'h000B,16'h000C,16'h000D};
        vec[12] = '{16'h0000,0,0,0, 1,0,0,8'd2, 16'h00F2,16'h000B,16'h000C,16'h000D};
        vec[13] = '{16'h7777,0,1,0, 1,0,0,8'd2, 16'h00F2,16'h000B,16'h000C,16'h000D};

        do_reset();
        for (int n = 0; n < 14; n++) begin
            cycle(vec[n].i, vec[n].v, vec[n].sof, vec[n].ordy);
            chk($sformatf("vec%0d_rdy", n), 32'(rdy_seen), 32'(vec[n].rdy));
            chk($sformatf("vec%0d_ov", n), 32'(O_VALID), 32'(vec[n].ov));
            chk($sformatf("vec%0d_err", n), 32'(ERR), 32'(vec[n].err));
            chk($sformatf("vec%0d_ecnt", n), 32'(ERR_CNT), 32'(vec[n].ecnt));
            chk($sformatf("vec%0d_o0", n), 32'(O0), 32'(vec[n].o0));
            chk($sformatf("vec%0d_o1", n), 32'(O1), 32'(vec[n].o1));
            chk($sformatf("vec%0d_o2", n), 32'(O2), 32'(vec[n].o2));
            chk($sformatf("vec%0d_o3", n), 32'(O3), 32'(vec[n].o3));
        end

        // Back-to-back frames at full rate: O_VALID only after words 4 and 8.
        do_reset();
        for (int n = 0; n < 8; n++) begin
            cycle(16'(16'h0100 + n), 1'b1, (n % 4) == 0, 1'b1);
            chk("b2b_ready", 32'(rdy_seen), 32'd1);
            chk("b2b_ov", 32'(O_VALID), 32'((n == 3) || (n == 7)));
            if (n == 7) begin
                chk("b2b_o0", 32'(O0), 32'h0104);
                chk("b2b_o3", 32'(O3), 32'h0107);
            end
        end

        // Stalled consumer: lane 3 of frame 2 waits until frame 1 is taken.
        do_reset();
        for (int n = 0; n < 4; n++) cycle(16'(16'hA0 + n), 1'b1, n == 0, 1'b0);
        chk("stall_f1_ov", 32'(O_VALID), 32'd1);
        for (int n = 0; n < 3; n++) begin
            cycle(16'(16'hB0 + n), 1'b1, n == 0, 1'b0);
            chk("stall_lane_rdy", 32'(rdy_seen), 32'd1);
            chk("stall_hold_o0", 32'(O0), 32'h00A0);
        end
        for (int n = 0; n < 2; n++) begin
            cycle(16'h00B3, 1'b1, 1'b0, 1'b0);
            chk("stall_lane3_blocked", 32'(rdy_seen), 32'd0);
            chk("stall_hold_o3", 32'(O3), 32'h00A3);
            chk("stall_ov", 32'(O_VALID), 32'd1);
        end
        cycle(16'h00B3, 1'b1, 1'b0, 1'b1);
        chk("stall_release_rdy", 32'(rdy_seen), 32'd1);
        chk("stall_f2_ov", 32'(O_VALID), 32'd1);
        chk("stall_f2_o0", 32'(O0), 32'h00B0);
        chk("stall_f2_o3", 32'(O3), 32'h00B3);
        cycle(16'h0, 1'b0, 1'b0, 1'b1);
        chk("stall_drain_ov", 32'(O_VALID), 32'd0);

        // Orphan words repeated: counter saturates at 255, no output.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            cycle(16'h1234, 1'b1, 1'b0, 1'b1);
            chk("orphan_err", 32'(ERR), 32'd1);
        end
        chk("orphan_sat", 32'(ERR_CNT), 32'd255);
        chk("orphan_ov", 32'(O_VALID), 32'd0);
        cycle(16'h0, 1'b0, 1'b0, 1'b1);
        chk("orphan_err_clear", 32'(ERR), 32'd0);

        // Reset mid-frame discards the partial frame.
        do_reset();
        cycle(16'h0E01, 1'b1, 1'b1, 1'b1);
        cycle(16'h0E02, 1'b1, 1'b0, 1'b1);
        do_reset();
        for (int n = 0; n < 4; n++) cycle(16'(16'h0C00 + n), 1'b1, n == 0, 1'b1);
        chk("midrst_ov", 32'(O_VALID), 32'd1);
        chk("midrst_o0", 32'(O0), 32'h0C00);
        chk("midrst_o1", 32'(O1), 32'h0C01);
        chk("midrst_ecnt", 32'(ERR_CNT), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic v, sof, ordy;
            v    = $urandom_range(0, 9) != 0;
            sof  = (m_part.size() == 0) ? ($urandom_range(0, 9) != 0)
                                        : ($urandom_range(0, 12) == 0);
            ordy = $urandom_range(0, 9) < 7;
            cycle(16'($urandom), v, sof, ordy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
